fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares the single framebuffer port B (gpu_clk domain) between NUM_REQ requesters, e.g. the display-processor data path (requester 0) and a fill/blit engine (requester 1).
- Round-robin arbitration with optional burst lock and a starvation cap.
- Routes read data back to the issuing requester after the fixed memory read latency.
- Sits between the requesters and framebuffer_port_b_*; the framebuffer itself is unchanged.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- ADDR_W, 32, address width.
- RD_LATENCY, 1, cycles from an accepted read on the port to valid fb_rd_data (>=1).
- MAX_BURST, 16, max consecutive locked transfers before a forced rotation.

Ports:
- gpu_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester access request.
- req_ready  out  NUM_REQ  per-requester grant; the transfer is accepted when valid&ready.
- req_lock  in  NUM_REQ  holds the grant across consecutive transfers (burst).
- req_addr  in  NUM_REQ x ADDR_W  per-requester address.
- req_wr_data  in  NUM_REQ x 32  per-requester write data.
- req_wr_en  in  NUM_REQ x 4  byte write enables; all-zero means read.
- rsp_valid  out  NUM_REQ  one-cycle pulse when the read data for that requester is on rsp_rd_data.
- rsp_rd_data  out  32  read data, broadcast to all requesters (qualify with rsp_valid).
- fb_address  out  ADDR_W  to framebuffer port B.
- fb_wr_data  out  32  to framebuffer port B.
- fb_wr_en  out  4  to framebuffer port B.
- fb_rd_data  in  32  from framebuffer port B.

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, fb_wr_en=0, fb_address=0, fb_wr_data=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - burst_cnt=0; response pipeline cleared.
- Grant is combinational from registered state plus current req_valid. At most one req_ready bit is high; it is high only if that requester's valid is high. Accept is the same cycle as grant.
- Owner hold: if req_valid[last_grant] & req_lock[last_grant] & burst_cnt<MAX_BURST, grant last_grant.
- Otherwise round-robin: the first valid requester searching from last_grant+1 upward, wrapping at NUM_REQ. The owner itself is searched last.
- burst_cnt:
  - On an accepted transfer by the same owner with lock=1: increment, saturating at MAX_BURST.
  - On an accepted transfer by a different requester, or with lock=0: set to 1 if lock=1, else 0.
- Forced rotation: when burst_cnt==MAX_BURST and any other requester is valid, the round-robin search excludes the owner. If no other requester is valid, the owner keeps the grant and burst_cnt stays saturated.
- Port drive:
  - Accepted cycle: fb_* = the granted requester's addr/wr_data/wr_en.
  - No accept: fb_wr_en=0 and fb_address holds its last value. There are no spurious writes; idle reads are harmless.
- Read tracking: a shift register RD_LATENCY deep of {valid, onehot id} records accepted reads (wr_en==0). At the tail, rsp_valid[id]=1 and rsp_rd_data=fb_rd_data.
- Accepted writes produce no response.
- Back-to-back reads, alternating requesters, are supported every cycle. Throughput is 1 transfer/cycle.
- Requester rules: a requester must hold valid/addr/data stable until accepted. It may drop lock at any time; the drop takes effect for the next arbitration.
- Reset mid-operation: in-flight reads are discarded (no rsp_valid after reset). The grant returns to requester 0 priority.
- Simultaneous deassert of the owner's valid with another requester's request: the other requester is granted the same cycle.

Decomposition:
- gpu_pkg gets:
  - localparam FB_RD_LATENCY.
  - typedef fb_req_t {addr, wr_data, wr_en}.
  - typedef req_id_t (NUM_REQ-bit onehot).
- Sub-module rr_priority_picker (combinational): inputs are the request vector, the start pointer and the exclude mask; output is the onehot grant. It is reusable by data_bus_arbitrator.

Test Plan:
- Reset, then both requesters valid reading addr 0x10/0x20 continuously, no lock -> grants alternate 0,1,0,1 starting with 0. rsp_valid[0] returns data @0x10 exactly RD_LATENCY cycles after each accept; same for [1].
- Req0 locked burst of 20 reads while req1 is valid -> req0 gets 16 consecutive grants, req1 gets 1, then req0 resumes. With req1 idle, req0 gets all 20 uninterrupted.
- Req1 writes 0xA5 with wr_en=4'b0001 to addr 5, then req0 reads addr 5 next cycle -> fb_wr_en=1 only in the write cycle. Req0's rsp_rd_data low byte is 0xA5 and rsp_valid[1] never pulses.
- Reset asserted one cycle after a req0 read is accepted (RD_LATENCY=2) -> no rsp_valid afterwards, req_ready=0 during reset, first post-reset grant goes to req0.
- Only req1 valid for 5 cycles, then req0 also valid -> req1 granted for 5 cycles with zero wait. In the next contended cycle req0 wins (round-robin from last_grant=1).

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared framebuffer-side types and defaults for the GPU memory arbiters.
package gpu_pkg;

  localparam int unsigned FB_NUM_REQ    = 2;
  localparam int unsigned FB_ADDR_W     = 32;
  localparam int unsigned FB_RD_LATENCY = 1;
  localparam int unsigned FB_MAX_BURST  = 16;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [31:0]          wr_data;
    logic [3:0]           wr_en;
  } fb_req_t;

  typedef logic [FB_NUM_REQ-1:0] req_id_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first non-excluded request at or after start, wrapping.
module rr_priority_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     exclude,
  output logic [N-1:0]     grant
);

  logic [N-1:0] cand;
  logic         found;
  int unsigned  idx;

  always_comb begin
    cand  = req & ~exclude;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(start) + i) % N;
      if (!found && cand[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares framebuffer port B between NUM_REQ requesters: round-robin with burst lock,
// starvation cap, and read-response routing after the fixed memory latency.
module fb_port_arbiter
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_REQ    = FB_NUM_REQ,
  parameter int unsigned ADDR_W     = FB_ADDR_W,
  parameter int unsigned RD_LATENCY = FB_RD_LATENCY,
  parameter int unsigned MAX_BURST  = FB_MAX_BURST
) (
  input  logic                           gpu_clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0]       req_wr_data,
  input  logic [NUM_REQ-1:0][3:0]        req_wr_en,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [31:0]                    rsp_rd_data,
  output logic [ADDR_W-1:0]              fb_address,
  output logic [31:0]                    fb_wr_data,
  output logic [3:0]                     fb_wr_en,
  input  logic [31:0]                    fb_rd_data
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BC_W  = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [BC_W-1:0]  BC_MAX   = BC_W'(MAX_BURST);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_en;
  } sel_t;

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] start_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [BC_W-1:0]  burst_cnt;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] exclude;
  logic [NUM_REQ-1:0] rr_grant;
  logic [NUM_REQ-1:0] grant;
  logic owner_hold;
  logic others_valid;
  logic accept;
  logic accept_rd;
  sel_t sel;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wr_data_q;
  logic [RD_LATENCY-1:0]              pipe_vld;
  logic [RD_LATENCY-1:0][NUM_REQ-1:0] pipe_id;

  // Starting one past the owner makes the owner the last candidate in the search.
  always_comb begin
    owner_oh             = '0;
    owner_oh[last_grant] = 1'b1;
    others_valid = |(req_valid & ~owner_oh);
    owner_hold   = req_valid[last_grant] & req_lock[last_grant] & (burst_cnt < BC_MAX);
    exclude      = ((burst_cnt == BC_MAX) && others_valid) ? owner_oh : '0;
    start_ptr    = (last_grant == LAST_IDX) ? '0 : last_grant + IDX_W'(1);
  end

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (req_valid),
    .start   (start_ptr),
    .exclude (exclude),
    .grant   (rr_grant)
  );

  always_comb begin
    grant     = reset ? '0 : (owner_hold ? owner_oh : rr_grant);
    accept    = |grant;
    grant_idx = '0;
    sel       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx   = IDX_W'(i);
        sel.addr    = req_addr[i];
        sel.wr_data = req_wr_data[i];
        sel.wr_en   = req_wr_en[i];
      end
    end
    accept_rd  = accept & (sel.wr_en == 4'b0000);
    fb_address = accept ? sel.addr : addr_q;
    fb_wr_data = accept ? sel.wr_data : wr_data_q;
    fb_wr_en   = accept ? sel.wr_en : '0;
  end

  assign req_ready   = grant;
  assign rsp_valid   = pipe_vld[RD_LATENCY-1] ? pipe_id[RD_LATENCY-1] : '0;
  assign rsp_rd_data = fb_rd_data;

  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      last_grant <= LAST_IDX;
      burst_cnt  <= '0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      pipe_vld   <= '0;
      pipe_id    <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant_idx;
        addr_q     <= fb_address;
        wr_data_q  <= fb_wr_data;
        if ((grant_idx == last_grant) && req_lock[grant_idx])
          burst_cnt <= (burst_cnt == BC_MAX) ? burst_cnt : burst_cnt + BC_W'(1);
        else
          burst_cnt <= req_lock[grant_idx] ? BC_W'(1) : '0;
      end
      pipe_vld[0] <= accept_rd;
      pipe_id[0]  <= accept_rd ? grant : '0;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a 2-cycle-latency framebuffer model.
module tb_fb_port_arbiter;
  import gpu_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXB = 16;

  localparam req_id_t GN = 2'b00;
  localparam req_id_t G0 = 2'b01;
  localparam req_id_t G1 = 2'b10;
  localparam logic [31:0] D10 = 32'h1111_0010;
  localparam logic [31:0] D20 = 32'h2222_0020;

  logic gpu_clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid, req_ready, req_lock, rsp_valid;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][31:0]   req_wr_data;
  logic [NREQ-1:0][3:0]    req_wr_en;
  logic [31:0] rsp_rd_data, fb_wr_data, fb_rd_data;
  logic [AW-1:0] fb_address;
  logic [3:0]    fb_wr_en;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256];
  logic [31:0] rd_p1, rd_p2;

  fb_port_arbiter #(
    .NUM_REQ    (NREQ),
    .ADDR_W     (AW),
    .RD_LATENCY (LAT),
    .MAX_BURST  (MAXB)
  ) dut (
    .gpu_clk     (gpu_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wr_data (req_wr_data),
    .req_wr_en   (req_wr_en),
    .rsp_valid   (rsp_valid),
    .rsp_rd_data (rsp_rd_data),
    .fb_address  (fb_address),
    .fb_wr_data  (fb_wr_data),
    .fb_wr_en    (fb_wr_en),
    .fb_rd_data  (fb_rd_data)
  );

  always #5 gpu_clk = ~gpu_clk;

  // Framebuffer port B model: byte-enabled write, read data two cycles after the address.
  always @(posedge gpu_clk) begin
    for (int b = 0; b < 4; b++)
      if (fb_wr_en[b]) mem[fb_address[7:0]][b*8 +: 8] <= fb_wr_data[b*8 +: 8];
    rd_p1 <= mem[fb_address[7:0]];
    rd_p2 <= rd_p1;
  end
  assign fb_rd_data = rd_p2;

  task automatic set_req(input int unsigned r, input fb_req_t q);
    req_addr[r]    = q.addr;
    req_wr_data[r] = q.wr_data;
    req_wr_en[r]   = q.wr_en;
  endtask

  task automatic set_idle;
    req_valid = '0;
    req_lock  = '0;
    req_wr_en = '0;
  endtask

  task automatic do_reset;
    @(negedge gpu_clk);
    reset = 1'b1;
    set_idle();
    @(negedge gpu_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge gpu_clk);
    reset = 1'b1;
    set_req(0, '{addr: 32'h10, wr_data: 32'h0, wr_en: 4'h0});
    set_req(1, '{addr: 32'h20, wr_data: 32'h0, wr_en: 4'h0});
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== GN) begin miscompares++; $display("FAIL rst_ready: got %b expected %b", req_ready, GN); end
    vectors++; if (fb_wr_en !== 4'h0) begin miscompares++; $display("FAIL rst_wr_en: got %h expected 0", fb_wr_en); end
    @(negedge gpu_clk); #1;
    vectors++; if (fb_address !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", fb_address); end
    vectors++; if (fb_wr_data !== 32'h0) begin miscompares++; $display("FAIL rst_wdata: got %h expected 0", fb_wr_data); end
    vectors++; if (rsp_valid !== GN) begin miscompares++; $display("FAIL rst_rsp: got %b expected %b", rsp_valid, GN); end
    @(negedge gpu_clk);
    reset = 1'b0;
    req_valid = 2'b00;
    #1;
    vectors++; if (req_ready !== GN) begin miscompares++; $display("FAIL rst_idle_ready: got %b expected %b", req_ready, GN); end
    @(negedge gpu_clk);
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== G0) begin miscompares++; $display("FAIL rst_first_grant: got %b expected %b", req_ready, G0); end
    vectors++; if (fb_address !== 32'h10) begin miscompares++; $display("FAIL rst_first_addr: got %h expected 10", fb_address); end
  endtask

  task automatic test_alternate;
    req_id_t hist [12];
    req_id_t eg, er;
    do_reset();
    set_req(0, '{addr: 32'h10, wr_data: 32'h0, wr_en: 4'h0});
    set_req(1, '{addr: 32'h20, wr_data: 32'h0, wr_en: 4'h0});
    for (int c = 0; c < 12; c++) begin
      @(negedge gpu_clk);
      req_valid = (c < 8) ? 2'b11 : 2'b00;
      #1;
      eg = (c >= 8) ? GN : ((c % 2 == 0) ? G0 : G1);
      hist[c] = eg;
      er = (c >= 2) ? hist[c-2] : GN;
      vectors++; if (req_ready !== eg) begin miscompares++; $display("FAIL alt_ready c%0d: got %b expected %b", c, req_ready, eg); end
      vectors++; if (rsp_valid !== er) begin miscompares++; $display("FAIL alt_rsp c%0d: got %b expected %b", c, rsp_valid, er); end
      if (er == G0) begin
        vectors++; if (rsp_rd_data !== D10) begin miscompares++; $display("FAIL alt_data0 c%0d: got %h expected %h", c, rsp_rd_data, D10); end
      end else if (er == G1) begin
        vectors++; if (rsp_rd_data !== D20) begin miscompares++; $display("FAIL alt_data1 c%0d: got %h expected %h", c, rsp_rd_data, D20); end
      end
    end
  endtask

  task automatic test_burst;
    int rem0, rem1;
    req_id_t eg;
    do_reset();
    set_req(0, '{addr: 32'h10, wr_data: 32'h0, wr_en: 4'h0});
    set_req(1, '{addr: 32'h20, wr_data: 32'h0, wr_en: 4'h0});
    rem0 = 20;
    rem1 = 1;
    for (int c = 0; c < 22; c++) begin
      @(negedge gpu_clk);
      req_valid[0] = (rem0 > 0);
      req_lock[0]  = (rem0 > 0);
      req_valid[1] = (rem1 > 0);
      #1;
      eg = (c < 16 || (c >= 17 && c < 21)) ? G0 : ((c == 16) ? G1 : GN);
      vectors++; if (req_ready !== eg) begin miscompares++; $display("FAIL burst_cap c%0d: got %b expected %b", c, req_ready, eg); end
      if (req_ready[0]) rem0--;
      if (req_ready[1]) rem1--;
    end
    do_reset();
    rem0 = 20;
    for (int c = 0; c < 21; c++) begin
      @(negedge gpu_clk);
      req_valid[0] = (rem0 > 0);
      req_lock[0]  = (rem0 > 0);
      #1;
      eg = (c < 20) ? G0 : GN;
      vectors++; if (req_ready !== eg) begin miscompares++; $display("FAIL burst_solo c%0d: got %b expected %b", c, req_ready, eg); end
      if (req_ready[0]) rem0--;
    end
  endtask

  task automatic test_write_read;
    do_reset();
    set_req(1, '{addr: 32'h5, wr_data: 32'h0000_00A5, wr_en: 4'b0001});
    set_req(0, '{addr: 32'h5, wr_data: 32'h0, wr_en: 4'h0});
    @(negedge gpu_clk);
    req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== G1) begin miscompares++; $display("FAIL wr_ready: got %b expected %b", req_ready, G1); end
    vectors++; if (fb_wr_en !== 4'b0001) begin miscompares++; $display("FAIL wr_en: got %b expected 0001", fb_wr_en); end
    vectors++; if (fb_address !== 32'h5) begin miscompares++; $display("FAIL wr_addr: got %h expected 5", fb_address); end
    vectors++; if (fb_wr_data !== 32'hA5) begin miscompares++; $display("FAIL wr_data: got %h expected a5", fb_wr_data); end
    @(negedge gpu_clk);
    req_wr_en[1] = 4'h0;
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== G0) begin miscompares++; $display("FAIL rd_ready: got %b expected %b", req_ready, G0); end
    vectors++; if (fb_wr_en !== 4'h0) begin miscompares++; $display("FAIL rd_wr_en: got %b expected 0000", fb_wr_en); end
    @(negedge gpu_clk);
    req_valid = 2'b00;
    #1;
    vectors++; if (fb_wr_en !== 4'h0) begin miscompares++; $display("FAIL idle_wr_en: got %b expected 0000", fb_wr_en); end
    vectors++; if (fb_address !== 32'h5) begin miscompares++; $display("FAIL idle_addr_hold: got %h expected 5", fb_address); end
    vectors++; if (rsp_valid !== GN) begin miscompares++; $display("FAIL wr_no_rsp: got %b expected %b", rsp_valid, GN); end
    @(negedge gpu_clk); #1;
    vectors++; if (rsp_valid !== G0) begin miscompares++; $display("FAIL rd_rsp: got %b expected %b", rsp_valid, G0); end
    vectors++; if (rsp_rd_data !== 32'h1234_56A5) begin miscompares++; $display("FAIL rd_data: got %h expected 123456a5", rsp_rd_data); end
    @(negedge gpu_clk); #1;
    vectors++; if (rsp_valid !== GN) begin miscompares++; $display("FAIL rd_rsp_end: got %b expected %b", rsp_valid, GN); end
  endtask

  task automatic test_reset_inflight;
    do_reset();
    set_req(0, '{addr: 32'h10, wr_data: 32'h0, wr_en: 4'h0});
    set_req(1, '{addr: 32'h20, wr_data: 32'h0, wr_en: 4'h0});
    @(negedge gpu_clk);
    req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== G0) begin miscompares++; $display("FAIL inflt_accept: got %b expected %b", req_ready, G0); end
    @(negedge gpu_clk);
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== GN) begin miscompares++; $display("FAIL inflt_rst_ready: got %b expected %b", req_ready, GN); end
    @(negedge gpu_clk);
    reset = 1'b0;
    #1;
    vectors++; if (rsp_valid !== GN) begin miscompares++; $display("FAIL inflt_discard: got %b expected %b", rsp_valid, GN); end
    vectors++; if (req_ready !== G0) begin miscompares++; $display("FAIL inflt_post_grant: got %b expected %b", req_ready, G0); end
    @(negedge gpu_clk);
    req_valid = 2'b10;
    #1;
    vectors++; if (rsp_valid !== GN) begin miscompares++; $display("FAIL inflt_quiet: got %b expected %b", rsp_valid, GN); end
    vectors++; if (req_ready !== G1) begin miscompares++; $display("FAIL inflt_grant1: got %b expected %b", req_ready, G1); end
    @(negedge gpu_clk);
    req_valid = 2'b00;
    #1;
    vectors++; if (rsp_valid !== G0) begin miscompares++; $display("FAIL inflt_new_rsp: got %b expected %b", rsp_valid, G0); end
    vectors++; if (rsp_rd_data !== D10) begin miscompares++; $display("FAIL inflt_new_data: got %h expected %h", rsp_rd_data, D10); end
  endtask

  task automatic test_idle_then_contend;
    req_id_t eg;
    do_reset();
    set_req(0, '{addr: 32'h10, wr_data: 32'h0, wr_en: 4'h0});
    set_req(1, '{addr: 32'h20, wr_data: 32'h0, wr_en: 4'h0});
    for (int c = 0; c < 8; c++) begin
      @(negedge gpu_clk);
      req_valid = (c < 5) ? 2'b10 : 2'b11;
      #1;
      eg = (c < 5) ? G1 : ((c % 2 == 1) ? G0 : G1);
      vectors++; if (req_ready !== eg) begin miscompares++; $display("FAIL contend c%0d: got %b expected %b", c, req_ready, eg); end
    end
  endtask

  task automatic test_handoff;
    do_reset();
    set_req(0, '{addr: 32'h10, wr_data: 32'h0, wr_en: 4'h0});
    set_req(1, '{addr: 32'h20, wr_data: 32'h0, wr_en: 4'h0});
    @(negedge gpu_clk);
    req_valid = 2'b01;
    req_lock  = 2'b01;
    #1;
    vectors++; if (req_ready !== G0) begin miscompares++; $display("FAIL hand_own: got %b expected %b", req_ready, G0); end
    @(negedge gpu_clk);
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== G0) begin miscompares++; $display("FAIL hand_hold: got %b expected %b", req_ready, G0); end
    @(negedge gpu_clk);
    req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== G1) begin miscompares++; $display("FAIL hand_switch: got %b expected %b", req_ready, G1); end
    @(negedge gpu_clk);
    req_valid = 2'b11;
    req_lock  = 2'b00;
    #1;
    vectors++; if (req_ready !== G0) begin miscompares++; $display("FAIL hand_unlock: got %b expected %b", req_ready, G0); end
    @(negedge gpu_clk);
    #1;
    vectors++; if (req_ready !== G1) begin miscompares++; $display("FAIL hand_rotate: got %b expected %b", req_ready, G1); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = D10;
    mem[8'h20] = D20;
    mem[8'h05] = 32'h1234_5678;
    reset = 1'b1;
    req_addr = '0;
    req_wr_data = '0;
    set_idle();
    test_reset();
    test_alternate();
    test_burst();
    test_write_read();
    test_reset_inflight();
    test_idle_then_contend();
    test_handoff();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
